// File: rtl/mutative_pkg.sv
// rtl/mutative_pkg.sv - shared op/state encodings and word geometry for mutative_data_ctrl
package mutative_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int WORDS_PER_LINE = 256 / WORD_WIDTH;
    localparam int NUM_WMASKS     = 256 / 8;

    typedef enum logic [1:0] {
        OP_WORD_RD = 2'b00,
        OP_WORD_WR = 2'b01,
        OP_LINE_RD = 2'b10,
        OP_LINE_WR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_CAP  = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/mutative_data_ctrl_if.sv
// rtl/mutative_data_ctrl_if.sv - request/response channel between cache pipeline and mutative_data_ctrl
interface mutative_data_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 256
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [ADDR_WIDTH-1:0] req_index;
    logic [2:0]            req_offset;
    logic [3:0]            req_bmask;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_op;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_op, req_index, req_offset, req_bmask, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_op, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_index, req_offset, req_bmask, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_op, rsp_data
    );
endinterface

// File: rtl/mutative_word_lane.sv
// rtl/mutative_word_lane.sv - word offset to byte-mask shift, write-word replication, read-word extraction
module mutative_word_lane
    import mutative_pkg::*;
#(
    parameter int DATA_WIDTH = 256
) (
    input  logic [2:0]            wr_offset,
    input  logic [3:0]            bmask,
    input  logic [WORD_WIDTH-1:0] wr_word,
    input  logic [2:0]            rd_offset,
    input  logic [DATA_WIDTH-1:0] rd_line,
    output logic [NUM_WMASKS-1:0] wmask,
    output logic [DATA_WIDTH-1:0] din_rep,
    output logic [DATA_WIDTH-1:0] rd_word
);

    logic [NUM_WMASKS-1:0] mask_base;

    assign mask_base = {{(NUM_WMASKS-4){1'b0}}, bmask};
    assign wmask     = mask_base << {wr_offset, 2'b00};
    // Every lane carries the word; the byte mask alone selects which one lands.
    assign din_rep   = {WORDS_PER_LINE{wr_word}};
    assign rd_word   = {{(DATA_WIDTH-WORD_WIDTH){1'b0}}, rd_line[WORD_WIDTH*rd_offset +: WORD_WIDTH]};

endmodule

// File: rtl/mutative_data_ctrl.sv
// rtl/mutative_data_ctrl.sv - access controller for the 16x256 mutative data array (option: MUTATIVE_WR_ACK_EN)
module mutative_data_ctrl
    import mutative_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    mutative_data_ctrl_if.slave   bus,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [NUM_WMASKS-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    state_e                state_q, state_d;
    logic [1:0]            op_q;
    logic [2:0]            offset_q;
    logic [1:0]            rsp_op_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  accept;
    logic [NUM_WMASKS-1:0] lane_wmask;
    logic [DATA_WIDTH-1:0] lane_din;
    logic [DATA_WIDTH-1:0] lane_rd_word;

    mutative_word_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .wr_offset (bus.req_offset),
        .bmask     (bus.req_bmask),
        .wr_word   (bus.req_wdata[WORD_WIDTH-1:0]),
        .rd_offset (offset_q),
        .rd_line   (sram_dout),
        .wmask     (lane_wmask),
        .din_rep   (lane_din),
        .rd_word   (lane_rd_word)
    );

    assign bus.req_ready = rstb0 && (state_q == ST_IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_op    = rsp_op_q;
    assign bus.rsp_data  = rsp_data_q;
    assign sram_addr     = bus.req_index;

    always_comb begin
        state_d    = state_q;
        sram_csb   = 1'b1;
        sram_web   = 1'b1;
        sram_wmask = '0;
        sram_din   = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sram_csb = 1'b0;
                    sram_web = !bus.req_op[0];
                    if (bus.req_op[0]) begin
                        sram_wmask = bus.req_op[1] ? {NUM_WMASKS{1'b1}} : lane_wmask;
                        sram_din   = bus.req_op[1] ? bus.req_wdata : lane_din;
                    end
                    if (!bus.req_op[0]) begin
                        state_d = ST_RD_CAP;
                    end else begin
`ifdef MUTATIVE_WR_ACK_EN
                        state_d = ST_WR_WAIT;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
            ST_RD_CAP:  state_d = ST_RESP;
            ST_WR_WAIT: state_d = ST_RESP;
            ST_RESP:    if (bus.rsp_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            state_q    <= ST_IDLE;
            op_q       <= 2'b00;
            offset_q   <= 3'd0;
            rsp_op_q   <= 2'b00;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q     <= bus.req_op;
                offset_q <= bus.req_offset;
            end
            // Array output is valid only in the cycle after the accept edge.
            if (state_q == ST_RD_CAP) begin
                rsp_op_q   <= op_q;
                rsp_data_q <= op_q[1] ? sram_dout : lane_rd_word;
            end
            if (state_q == ST_WR_WAIT) begin
                rsp_op_q   <= op_q;
                rsp_data_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mutative_data_ctrl.sv
// tb/tb_mutative_data_ctrl.sv - directed bench for mutative_data_ctrl with a registered-input array model
module tb_mutative_data_ctrl;
    import mutative_pkg::*;

    logic                  clk0 = 1'b0;
    logic                  rstb0;
    logic                  sram_csb, sram_web;
    logic [NUM_WMASKS-1:0] sram_wmask;
    logic [3:0]            sram_addr;
    logic [255:0]          sram_din;
    logic [255:0]          sram_dout;
    logic [255:0]          mem [16];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic                  snap_csb, snap_web;
    logic [NUM_WMASKS-1:0] snap_wmask;
    logic [255:0]          snap_din;

    mutative_data_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(256)) bus ();

    mutative_data_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(256)) dut (
        .clk0       (clk0),
        .rstb0      (rstb0),
        .bus        (bus),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
    );

    always #5 clk0 = ~clk0;

    always @(posedge clk0) cyc <= cyc + 1;

    always @(posedge clk0) begin
        if (!sram_csb) begin
            if (!sram_web) begin
                for (int b = 0; b < NUM_WMASKS; b++)
                    if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
            end else begin
                sram_dout <= mem[sram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] idx, input logic [2:0] off,
                         input logic [3:0] bm, input logic [255:0] wd);
        int n = 0;
        @(negedge clk0);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk0);
            n++;
        end
        if (!bus.req_ready) check("req_ready_wait", bus.req_ready, 1);
        bus.req_op     = op;
        bus.req_index  = idx;
        bus.req_offset = off;
        bus.req_bmask  = bm;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        #1;
        snap_csb   = sram_csb;
        snap_web   = sram_web;
        snap_wmask = sram_wmask;
        snap_din   = sram_din;
        @(posedge clk0);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [1:0] op, input logic [255:0] data);
        int n = 0;
        @(negedge clk0);
        check({tag, "_early"}, bus.rsp_valid, 0);
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk0);
            n++;
        end
        check({tag, "_lat"}, n, 1);
        check({tag, "_valid"}, bus.rsp_valid, 1);
        check({tag, "_op"}, bus.rsp_op, op);
        check({tag, "_data"}, bus.rsp_data, data);
        @(posedge clk0);
        #1;
    endtask

    task automatic wr(input string tag, input logic [1:0] op, input logic [3:0] idx,
                      input logic [2:0] off, input logic [3:0] bm, input logic [255:0] wd);
        issue(op, idx, off, bm, wd);
`ifdef MUTATIVE_WR_ACK_EN
        wait_rsp(tag, op, '0);
`else
        @(negedge clk0);
        check({tag, "_ready_held"}, bus.req_ready, 1);
`endif
    endtask

    logic [255:0] pat_a5, pat_7, line5;
    int c0, nrsp;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        sram_dout = '0;
        pat_a5 = {32{8'hA5}};
        pat_7  = {8{32'h0123_4567}} ^ {4{64'hFEDC_BA98_7654_3210}};
        line5  = 256'h00AD00EF << 64;
        rstb0 = 1'b0;
        bus.rsp_ready  = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_op     = OP_WORD_WR;
        bus.req_index  = 4'd1;
        bus.req_offset = 3'd0;
        bus.req_bmask  = 4'hF;
        bus.req_wdata  = '1;
        repeat (3) @(negedge clk0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_csb", sram_csb, 1);
        check("rst_web", sram_web, 1);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_op", bus.rsp_op, 0);
        bus.req_valid = 1'b0;
        rstb0 = 1'b1;
        #1 check("rst_release_ready", bus.req_ready, 1);

        // Line write then line read of index 3.
        issue(OP_LINE_WR, 4'd3, 3'd5, 4'h0, pat_a5);
        check("lw_csb", snap_csb, 0);
        check("lw_web", snap_web, 0);
        check("lw_wmask", snap_wmask, {NUM_WMASKS{1'b1}});
        check("lw_din", snap_din, pat_a5);
`ifdef MUTATIVE_WR_ACK_EN
        wait_rsp("lw_ack", OP_LINE_WR, '0);
`endif
        issue(OP_LINE_RD, 4'd3, 3'd0, 4'h0, '0);
        check("lr_web", snap_web, 1);
        check("lr_wmask", snap_wmask, 0);
        wait_rsp("lr3", OP_LINE_RD, pat_a5);

        // Partial word write over a zeroed line.
        wr("z5", OP_LINE_WR, 4'd5, 3'd0, 4'h0, '0);
        issue(OP_WORD_WR, 4'd5, 3'd2, 4'b0101, {224'hFFFF, 32'hDEADBEEF});
        check("ww_wmask", snap_wmask, 32'h0000_0500);
        check("ww_din", snap_din, {8{32'hDEADBEEF}});
`ifdef MUTATIVE_WR_ACK_EN
        wait_rsp("ww_ack", OP_WORD_WR, '0);
`endif
        issue(OP_WORD_RD, 4'd5, 3'd2, 4'h0, '0);
        wait_rsp("wr5o2", OP_WORD_RD, 256'h00AD00EF);
        issue(OP_WORD_RD, 4'd5, 3'd3, 4'h0, '0);
        wait_rsp("wr5o3", OP_WORD_RD, 256'h0);
        wr("bm0", OP_WORD_WR, 4'd5, 3'd3, 4'h0, {8{32'hFFFF_FFFF}});
        issue(OP_LINE_RD, 4'd5, 3'd0, 4'h0, '0);
        wait_rsp("lr5", OP_LINE_RD, line5);

        // Write index 7 immediately followed by a read of index 7.
        issue(OP_LINE_WR, 4'd7, 3'd0, 4'h0, pat_7);
`ifdef MUTATIVE_WR_ACK_EN
        wait_rsp("w7_ack", OP_LINE_WR, '0);
`endif
        issue(OP_WORD_RD, 4'd7, 3'd5, 4'h0, '0);
        wait_rsp("raw7", OP_WORD_RD, {224'h0, pat_7[160 +: 32]});

        // Response back-pressure with a competing request held valid.
        bus.rsp_ready = 1'b0;
        issue(OP_LINE_RD, 4'd3, 3'd0, 4'h0, '0);
        @(negedge clk0);
        bus.req_op    = OP_LINE_RD;
        bus.req_index = 4'd5;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk0);
            check("stall_valid", bus.rsp_valid, 1);
            check("stall_data", bus.rsp_data, pat_a5);
            check("stall_ready", bus.req_ready, 0);
            check("stall_csb", sram_csb, 1);
            check("stall_web", sram_web, 1);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk0);
        @(negedge clk0);
        check("resume_csb", sram_csb, 0);
        @(posedge clk0);
        #1 bus.req_valid = 1'b0;
        wait_rsp("resume", OP_LINE_RD, line5);

        // Reset while the read capture is pending.
        issue(OP_LINE_RD, 4'd3, 3'd0, 4'h0, '0);
        @(negedge clk0);
        rstb0 = 1'b0;
        @(posedge clk0);
        #1;
        check("rstmid_valid", bus.rsp_valid, 0);
        check("rstmid_ready", bus.req_ready, 0);
        check("rstmid_data", bus.rsp_data, 0);
        @(negedge clk0);
        rstb0 = 1'b1;
        #1 check("rstmid_ready_up", bus.req_ready, 1);
        issue(OP_LINE_RD, 4'd3, 3'd0, 4'h0, '0);
        wait_rsp("post_rst", OP_LINE_RD, pat_a5);

        // Four back-to-back writes.
`ifdef MUTATIVE_WR_ACK_EN
        nrsp = 0;
        for (int i = 0; i < 4; i++) begin
            issue((i % 2) ? OP_LINE_WR : OP_WORD_WR, 4'(8 + i), 3'd7, 4'hF, {8{32'h2222_2222}});
            wait_rsp("b2b_ack", (i % 2) ? OP_LINE_WR : OP_WORD_WR, '0);
            if (bus.rsp_op == ((i % 2) ? OP_LINE_WR : OP_WORD_WR)) nrsp++;
        end
        check("b2b_nrsp", nrsp, 4);
`else
        issue(OP_WORD_WR, 4'd8, 3'd7, 4'hF, {8{32'h2222_2222}});
        c0 = cyc;
        issue(OP_LINE_WR, 4'd9, 3'd7, 4'hF, {8{32'h2222_2222}});
        issue(OP_WORD_WR, 4'd10, 3'd7, 4'hF, {8{32'h2222_2222}});
        issue(OP_LINE_WR, 4'd11, 3'd7, 4'hF, {8{32'h2222_2222}});
        check("b2b_cycles", cyc - c0, 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk0);
            check("b2b_no_rsp", bus.rsp_valid, 0);
        end
`endif
        issue(OP_WORD_RD, 4'd10, 3'd7, 4'h0, '0);
        wait_rsp("b2b_rd10", OP_WORD_RD, 256'h2222_2222);
        issue(OP_LINE_RD, 4'd9, 3'd0, 4'h0, '0);
        wait_rsp("b2b_rd9", OP_LINE_RD, {8{32'h2222_2222}});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mutative_data_ctrl.md
# mutative_data_ctrl

Access controller sitting directly upstream of the 16×256-bit mutative data array. Accepts word and line requests from the cache pipeline over a valid/ready handshake, converts them into single-cycle SRAM port-0 accesses (chip select, write enable, byte write mask, address, data), and returns read data through a registered, back-pressurable response channel. Handles the array's registered-input, one-cycle read latency so upstream logic never sees SRAM timing.

## Interface
- ADDR_WIDTH, 4, line index width (16 lines)
- DATA_WIDTH, 256, line width in bits
- WORD_WIDTH, 32, CPU word width; WORDS_PER_LINE = DATA_WIDTH/WORD_WIDTH = 8, NUM_WMASKS = DATA_WIDTH/8 = 32 (derived)

- clk0  in  1  clock; all logic on rising edge
- rstb0  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept
- req_op  in  2  00 word read, 01 word write, 10 line read, 11 line write
- req_index  in  ADDR_WIDTH  line index
- req_offset  in  3  word within line (word ops only)
- req_bmask  in  4  byte enables for word write
- req_wdata  in  DATA_WIDTH  line write data; word write uses [WORD_WIDTH-1:0]
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_op  out  2  op of the responding request
- rsp_data  out  DATA_WIDTH  line data, or word zero-extended; 0 for write acks
- sram_csb  out  1  array chip select, active low
- sram_web  out  1  array write enable, active low
- sram_wmask  out  NUM_WMASKS  byte write mask
- sram_addr  out  ADDR_WIDTH  array address
- sram_din  out  DATA_WIDTH  array write data
- sram_dout  in  DATA_WIDTH  array read data

## Operation
- FSM states: IDLE, RD_CAP, WR_WAIT, RESP.
- req_ready = rstb0 && state==IDLE. Accept = req_valid && req_ready at edge E.
- SRAM port driven combinationally from the request in IDLE: sram_csb = !(accept); sram_web = !req_op[0]; sram_addr = req_index. Outside the accept cycle: sram_csb=1, sram_web=1, wmask/din 0.
- Word write: sram_wmask = req_bmask << (4*req_offset); sram_din = low word replicated into all 8 lanes. bmask 0 issues a write that changes nothing.
- Line write: wmask all ones, din = req_wdata; offset/bmask ignored.
- Reads: IDLE→RD_CAP at E. In RD_CAP, word read captures sram_dout[32*offset +: 32] zero-extended; line read captures full sram_dout; → RESP at E+1.
- Writes: see Configuration.
- RESP: rsp_valid=1, rsp_data/rsp_op held stable until rsp_valid && rsp_ready; then → IDLE.
- Reset values: state IDLE, rsp_valid 0, rsp_data 0, rsp_op 0, sram_csb 1, sram_web 1, req_ready 0 while rstb0 low.
- Reset mid-operation: pending response dropped; a write already latched by the array still commits (array has no reset).

## Timing
- Read: accept at E, rsp_valid high from E+1 until handshake; minimum spacing between read accepts 3 cycles.
- Write without ack: accept at E, array commits at E+1, req_ready stays high; one write per cycle sustained.
- Write then read same index on consecutive edges (E, E+1): read returns the newly written data.
- rsp_ready held low: response and all SRAM inputs stable; no new accept.

## Configuration
- MUTATIVE_WR_ACK_EN defined: writes go IDLE→WR_WAIT at E, →RESP at E+1; rsp_valid from E+1 with rsp_op = write op, rsp_data 0; same spacing as reads.
- Undefined: writes produce no response; state stays IDLE; WR_WAIT unreachable.

## Structure
- mutative_pkg: op encoding enum, FSM state enum, WORD_WIDTH, WORDS_PER_LINE, NUM_WMASKS.
- One sub-module, mutative_word_lane: combinational offset-to-wmask shift, word replication, and read-word extraction.

## Test plan
- Line write index 3 data 0x…A5 pattern, then line read index 3 -> rsp_data equals pattern, rsp_valid at E+1.
- Word write index 5 offset 2 bmask 4'b0101 data 0xDEADBEEF over zeroed line -> sram_wmask 0x00000500; word read offset 2 returns 0x00AD00EF.
- Write index 7 at E, read index 7 at E+1 -> read returns written data.
- Read with rsp_ready low 10 cycles -> rsp_data stable, req_ready 0, sram_csb 1 throughout; accept resumes after handshake.
- Reset asserted in RD_CAP -> rsp_valid 0, state IDLE next cycle; req_ready 1 cycle after rstb0 rises.
- MUTATIVE_WR_ACK_EN on/off: 4 back-to-back writes -> ack mode yields 4 responses with rsp_op 01/11; off yields none and 4 accepts in 4 cycles.
